// File: rtl/alu_result_checker_if.sv
// Sample bus between the ALU under test and its result checker.
interface alu_result_checker_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned SEL_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [SEL_W-1:0] sel;
   logic [WIDTH-1:0] C;

   // Side that presents {A,B,sel,C} samples (ALU side / stimulus).
   modport master (
      output in_valid,
      output A,
      output B,
      output sel,
      output C,
      input  in_ready
   );

   // Side that consumes samples (the checker).
   modport slave (
      input  in_valid,
      input  A,
      input  B,
      input  sel,
      input  C,
      output in_ready
   );
endinterface

// File: rtl/alu_result_checker.sv
// Self-checking monitor for the 4-bit ALU: recomputes the expected result of
// each {A,B,sel,C} sample, keeps saturating pass/fail/illegal counters and
// latches the first mismatch of a session.
module alu_result_checker #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned SEL_W = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   alu_result_checker_if.slave bus,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pass_count,
   output logic [CNT_W-1:0] fail_count,
   output logic [CNT_W-1:0] illegal_count,
   output logic             error,
   output logic             all_pass,
   output logic [SEL_W-1:0] ff_sel,
   output logic [WIDTH-1:0] ff_exp,
   output logic [WIDTH-1:0] ff_act
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t state;

   // Stage-1 sample register
   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [SEL_W-1:0] s1_sel;
   logic [WIDTH-1:0] s1_c;

   // Combinational reference result for the stage-1 sample
   logic [WIDTH-1:0] exp_c;
   logic             exp_legal;

   logic accept;
   logic session_open;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   assign bus.in_ready  = (state == ST_RUN);
   assign accept        = bus.in_valid & bus.in_ready;
   assign session_open  = start & ((state == ST_IDLE) | (state == ST_DONE));
   assign all_pass      = done & (fail_count == '0) & (pass_count != '0);

   // Session FSM with registered busy/done flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_RUN;
                  busy  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (stop) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (!s1_valid) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            ST_DONE: begin
               if (start) begin
                  state <= ST_RUN;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // Stage 1: capture every accepted sample, one per cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_sel   <= '0;
         s1_c     <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_a   <= bus.A;
            s1_b   <= bus.B;
            s1_sel <= bus.sel;
            s1_c   <= bus.C;
         end
      end
   end

   // Reference ALU: unsigned operands, results truncated to WIDTH
   always_comb begin
      exp_c     = '0;
      exp_legal = 1'b1;
      case (s1_sel)
         SEL_W'(0): exp_c = s1_a + s1_b;
         SEL_W'(1): exp_c = s1_a - s1_b;
         SEL_W'(2): exp_c = s1_a & s1_b;
         SEL_W'(3): exp_c = s1_a | s1_b;
         SEL_W'(4): exp_c = s1_a ^ s1_b;
         SEL_W'(5): exp_c = WIDTH'(s1_a == s1_b);
         SEL_W'(6): exp_c = WIDTH'(s1_a > s1_b);
         SEL_W'(7): exp_c = WIDTH'(s1_a < s1_b);
         SEL_W'(8): exp_c = s1_a >> 1;
         SEL_W'(9): exp_c = s1_a << 1;
         default:   exp_legal = 1'b0;
      endcase
   end

   // Stage 2: score the stage-1 sample into counters and first-fail capture.
   // A session can only open while stage 1 is empty, so clear and score never collide.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pass_count    <= '0;
         fail_count    <= '0;
         illegal_count <= '0;
         error         <= 1'b0;
         ff_sel        <= '0;
         ff_exp        <= '0;
         ff_act        <= '0;
      end else if (session_open) begin
         pass_count    <= '0;
         fail_count    <= '0;
         illegal_count <= '0;
         error         <= 1'b0;
         ff_sel        <= '0;
         ff_exp        <= '0;
         ff_act        <= '0;
      end else if (s1_valid) begin
         if (!exp_legal) begin
            illegal_count <= sat_inc(illegal_count);
         end else if (exp_c == s1_c) begin
            pass_count <= sat_inc(pass_count);
         end else begin
            fail_count <= sat_inc(fail_count);
            error      <= 1'b1;
            if (!error) begin
               ff_sel <= s1_sel;
               ff_exp <= exp_c;
               ff_act <= s1_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: one instance at CNT_W=8 and one at
// CNT_W=4 (saturation), both fed the same sample stream.
module tb_alu_result_checker;

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic stop;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_result_checker_if #(.WIDTH(4), .SEL_W(4)) u_if1 ();
   alu_result_checker_if #(.WIDTH(4), .SEL_W(4)) u_if2 ();

   logic       busy1, done1, error1, all_pass1;
   logic [7:0] pass1, fail1, ill1;
   logic [3:0] ff_sel1, ff_exp1, ff_act1;

   logic       busy2, done2, error2, all_pass2;
   logic [3:0] pass2, fail2, ill2;
   logic [3:0] ff_sel2, ff_exp2, ff_act2;

   alu_result_checker #(.WIDTH(4), .SEL_W(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .bus(u_if1.slave),
      .busy(busy1), .done(done1), .pass_count(pass1), .fail_count(fail1),
      .illegal_count(ill1), .error(error1), .all_pass(all_pass1),
      .ff_sel(ff_sel1), .ff_exp(ff_exp1), .ff_act(ff_act1)
   );

   alu_result_checker #(.WIDTH(4), .SEL_W(4), .CNT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .bus(u_if2.slave),
      .busy(busy2), .done(done2), .pass_count(pass2), .fail_count(fail2),
      .illegal_count(ill2), .error(error2), .all_pass(all_pass2),
      .ff_sel(ff_sel2), .ff_exp(ff_exp2), .ff_act(ff_act2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] s, input logic [3:0] c);
      u_if1.in_valid = v; u_if1.A = a; u_if1.B = b; u_if1.sel = s; u_if1.C = c;
      u_if2.in_valid = v; u_if2.A = a; u_if2.B = b; u_if2.sel = s; u_if2.C = c;
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 8; i++) begin
         if (done1 === 1'b1) break;
         cyc();
      end
      check(tag, {31'd0, done1}, 32'd1);
   endtask

   logic [3:0] c_vec[10];

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);

      // 1: reset state and session start
      repeat (3) cyc();
      check("rst_busy",     {31'd0, busy1}, 32'd0);
      check("rst_done",     {31'd0, done1}, 32'd0);
      check("rst_ready",    {31'd0, u_if1.in_ready}, 32'd0);
      check("rst_pass",     {24'd0, pass1}, 32'd0);
      check("rst_fail",     {24'd0, fail1}, 32'd0);
      check("rst_illegal",  {24'd0, ill1}, 32'd0);
      check("rst_error",    {31'd0, error1}, 32'd0);
      check("rst_all_pass", {31'd0, all_pass1}, 32'd0);
      check("rst_ff",       {20'd0, ff_sel1, ff_exp1, ff_act1}, 32'd0);
      rst_n = 1'b1;
      cyc();
      pulse_start();
      check("start_busy",  {31'd0, busy1}, 32'd1);
      check("start_ready", {31'd0, u_if1.in_ready}, 32'd1);

      // 2: A=5,B=2 over all legal opcodes, all correct
      c_vec = '{4'd7, 4'd3, 4'd0, 4'd7, 4'd7, 4'd0, 4'd1, 4'd0, 4'd2, 4'd10};
      for (int s = 0; s < 10; s++) begin
         drive(1'b1, 4'd5, 4'd2, 4'(s), c_vec[s]);
         cyc();
      end
      drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      check("t2_busy_drain", {31'd0, busy1}, 32'd1);
      wait_done("t2_done");
      check("t2_pass",     {24'd0, pass1}, 32'd10);
      check("t2_fail",     {24'd0, fail1}, 32'd0);
      check("t2_error",    {31'd0, error1}, 32'd0);
      check("t2_all_pass", {31'd0, all_pass1}, 32'd1);
      check("t2_busy",     {31'd0, busy1}, 32'd0);

      // 3: two wrong results; start mid-RUN must be ignored
      pulse_start();
      check("t3_cleared",   {24'd0, pass1}, 32'd0);
      check("t3_done_low",  {31'd0, done1}, 32'd0);
      c_vec[1] = 4'd4;
      c_vec[6] = 4'd0;
      for (int s = 0; s < 10; s++) begin
         drive(1'b1, 4'd5, 4'd2, 4'(s), c_vec[s]);
         start = (s == 5);
         cyc();
      end
      start = 1'b0;
      drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      wait_done("t3_done");
      check("t3_pass",     {24'd0, pass1}, 32'd8);
      check("t3_fail",     {24'd0, fail1}, 32'd2);
      check("t3_error",    {31'd0, error1}, 32'd1);
      check("t3_ff_sel",   {28'd0, ff_sel1}, 32'd1);
      check("t3_ff_exp",   {28'd0, ff_exp1}, 32'd3);
      check("t3_ff_act",   {28'd0, ff_act1}, 32'd4);
      check("t3_all_pass", {31'd0, all_pass1}, 32'd0);

      // 4: 20 back-to-back correct adds; CNT_W=4 instance saturates at 15
      pulse_start();
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 4'(i), 4'd1, 4'd0, 4'(i + 1));
         cyc();
      end
      drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      wait_done("t4_done");
      check("t4_pass8",      {24'd0, pass1}, 32'd20);
      check("t4_pass4_sat",  {28'd0, pass2}, 32'd15);
      check("t4_fail4",      {28'd0, fail2}, 32'd0);
      check("t4_all_pass4",  {31'd0, all_pass2}, 32'd1);

      // 5: illegal opcode, then a sample coincident with stop
      pulse_start();
      drive(1'b1, 4'd1, 4'd1, 4'd12, 4'd0);
      cyc();
      drive(1'b1, 4'd3, 4'd4, 4'd0, 4'd7);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
      check("t5_ready_drain", {31'd0, u_if1.in_ready}, 32'd0);
      wait_done("t5_done");
      check("t5_illegal",  {24'd0, ill1}, 32'd1);
      check("t5_pass",     {24'd0, pass1}, 32'd1);
      check("t5_fail",     {24'd0, fail1}, 32'd0);
      check("t5_error",    {31'd0, error1}, 32'd0);
      check("t5_all_pass", {31'd0, all_pass1}, 32'd1);

      // 6: reset mid-RUN with a sample in flight
      pulse_start();
      drive(1'b1, 4'd1, 4'd1, 4'd0, 4'd2);
      cyc();
      drive(1'b1, 4'd2, 4'd2, 4'd0, 4'd4);
      rst_n = 1'b0;
      cyc();
      drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
      check("t6_pass",  {24'd0, pass1}, 32'd0);
      check("t6_busy",  {31'd0, busy1}, 32'd0);
      check("t6_ready", {31'd0, u_if1.in_ready}, 32'd0);
      cyc();
      check("t6_pass_hold", {24'd0, pass1}, 32'd0);
      rst_n = 1'b1;
      cyc();
      pulse_start();
      drive(1'b1, 4'd6, 4'd3, 4'd1, 4'd3);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
      wait_done("t6_done");
      check("t6_pass_new", {24'd0, pass1}, 32'd1);
      check("t6_fail_new", {24'd0, fail1}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
